branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
// - Checks next-PC predictions made at fetch/issue against real branch outcomes from the ALU.
// - Holds one prediction record per in-flight ROB entry (JAL/JALR/B_TYPE only).
// - Raises a one-cycle flush with the corrected PC when a mispredicted control-flow instruction commits.
// - Keeps branch and misprediction statistics counters.
// PARAMETERS
// ROB_WIDTH  4  ROB tag width; table depth is 2**ROB_WIDTH entries.
// PORTS
// clk_in            in   1          clock, all state updates on rising edge
// rst_in            in   1          synchronous reset, active-high
// rdy_in            in   1          global ready; low freezes all state, outputs hold
// pred_valid        in   1          record a prediction this cycle
// pred_rob_id       in   ROB_WIDTH  ROB tag of the predicted instruction
// pred_op_type      in   7          opcode class (`JAL/`JALR/`B_TYPE; others ignored)
// pred_pc           in   32         PC of the instruction
// pred_is_c         in   1          1 = 16-bit compressed instruction, 0 = 32-bit
// pred_next_pc      in   32         next PC the fetch unit used
// res_valid         in   1          ALU outcome for a recorded entry
// res_rob_id        in   ROB_WIDTH  tag of the resolved instruction
// res_taken         in   1          branch/jump taken
// res_target        in   32         computed target (pc+imm or val1+imm)
// commit_valid      in   1          ROB commits an instruction
// commit_rob_id     in   ROB_WIDTH  tag being committed
// flush_out         out  1          one-cycle flush pulse
// redirect_pc_out   out  32         correct PC, valid while flush_out=1
// branch_cnt_out    out  32         committed control-flow instructions
// mispred_cnt_out   out  32         committed mispredictions
// proto_err_out     out  1          sticky: commit of a valid but unresolved entry
// BEHAVIOUR
// - Reset: all entries invalid; flush_out=0, redirect_pc_out=0, both counters=0, proto_err_out=0.
// - Entry fields: valid, resolved, mispred, pred_next_pc, fallthrough (pred_pc + (pred_is_c ? 2 : 4)), actual_pc.
// - Allocate (pred_valid, op in {JAL,JALR,B_TYPE}): entry <= valid=1, resolved=0. Other op types: no write.
// - JAL is resolved at allocation: resolved=1, mispred=0, actual_pc=pred_next_pc.
// - Resolve (res_valid, entry valid): actual = res_taken ? res_target : fallthrough.
//   mispred = (actual != pred_next_pc); resolved=1. res on an invalid entry is ignored.
// - Commit (commit_valid, entry valid & resolved): entry invalidated, branch_cnt_out += 1.
//   If mispred: mispred_cnt_out += 1; next cycle flush_out=1, redirect_pc_out=actual_pc.
//   Commit of a tag with no valid entry is a no-op (non-branch instruction).
//   Commit of a valid unresolved entry: entry invalidated, no counters, proto_err_out <= 1.
// - Latency: commit -> flush_out exactly 1 cycle; flush_out is high for exactly 1 cycle.
// - Flush cycle (flush_out=1): all entries invalidated at that edge; pred/res/commit inputs in that cycle ignored.
// - Simultaneous resolve and commit, same tag: resolve result bypassed to commit this cycle.
// - Simultaneous commit and allocate, same tag: commit processed on old contents, then allocate writes the new record.
// - Simultaneous allocate and resolve, same tag: allocate wins; resolve dropped.
// - Counters 32-bit unsigned, wrap from 0xFFFFFFFF to 0. Address arithmetic mod 2**32.
// - rdy_in=0: no state change, including pending flush (it issues once rdy_in returns).
// - Reset asserted mid-operation: state returns to reset values at that edge; pending flush discarded.
// TESTING
// - B_TYPE pc=0x100, 32-bit, pred_next=0x104; res taken target 0x140; commit -> next cycle flush=1, redirect=0x140, mispred_cnt=1.
// - B_TYPE pc=0x200, compressed, pred_next=0x202; res not taken; commit -> no flush, branch_cnt=1, mispred_cnt=0.
// - JALR pred_next=0x300, res target 0x300 with res and commit in the same cycle -> no flush; target 0x304 -> flush, redirect=0x304.
// - Two mispredicted entries (tags 3 and 5); commit tag 3 -> flush clears tag 5; later commit 5 -> no flush, counters unchanged.
// - Commit unresolved B_TYPE -> proto_err_out=1 and stays 1; rst_in pulse -> all outputs back to 0.
// - rdy_in=0 on the cycle after a mispredicted commit -> flush held off; rdy_in=1 -> single flush pulse, redirect correct.

Source files
------------

// File: rtl/branch_resolver.sv
// Tracks fetch next-PC predictions per ROB tag and checks them against ALU outcomes at commit.
// A mispredicted commit flushes one cycle later; rdy_in low freezes all state and holds any pending flush.
module branch_resolver #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 pred_valid,
  input  logic [ROB_WIDTH-1:0] pred_rob_id,
  input  logic [6:0]           pred_op_type,
  input  logic [31:0]          pred_pc,
  input  logic                 pred_is_c,
  input  logic [31:0]          pred_next_pc,
  input  logic                 res_valid,
  input  logic [ROB_WIDTH-1:0] res_rob_id,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 flush_out,
  output logic [31:0]          redirect_pc_out,
  output logic [31:0]          branch_cnt_out,
  output logic [31:0]          mispred_cnt_out,
  output logic                 proto_err_out
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam int DEPTH = 1 << ROB_WIDTH;

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic        mispred;
    logic [31:0] pred_next_pc;
    logic [31:0] fallthrough;
    logic [31:0] actual_pc;
  } entry_t;

  entry_t      tbl [DEPTH];
  logic        flush_q;
  logic [31:0] redirect_q;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
  logic        proto_err;

  entry_t      res_ent;
  entry_t      com_ent;
  logic [31:0] res_actual;
  logic        res_mispred;
  logic        bypass;
  logic        com_resolved;
  logic        com_mispred;
  logic [31:0] com_actual;
  logic        pred_is_br;
  logic        pred_is_jal;
  logic [31:0] pred_fallthrough;

  assign res_ent     = tbl[res_rob_id];
  assign com_ent     = tbl[commit_rob_id];
  assign res_actual  = res_taken ? res_target : res_ent.fallthrough;
  assign res_mispred = (res_actual != res_ent.pred_next_pc);

  // A resolve arriving in the same cycle as the commit of that tag is forwarded to the commit.
  assign bypass       = res_valid && res_ent.valid && (res_rob_id == commit_rob_id);
  assign com_resolved = com_ent.resolved | bypass;
  assign com_mispred  = bypass ? res_mispred : com_ent.mispred;
  assign com_actual   = bypass ? res_actual  : com_ent.actual_pc;

  assign pred_is_jal      = (pred_op_type == OP_JAL);
  assign pred_is_br       = pred_is_jal || (pred_op_type == OP_JALR) || (pred_op_type == OP_B_TYPE);
  assign pred_fallthrough = pred_pc + (pred_is_c ? 32'd2 : 32'd4);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
      proto_err   <= 1'b0;
    end else if (rdy_in) begin
      if (flush_q) begin
        flush_q <= 1'b0;
        for (int i = 0; i < DEPTH; i++) tbl[i].valid <= 1'b0;
      end else begin
        if (commit_valid && com_ent.valid) begin
          tbl[commit_rob_id].valid <= 1'b0;
          if (com_resolved) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (com_mispred) begin
              mispred_cnt <= mispred_cnt + 32'd1;
              flush_q     <= 1'b1;
              redirect_q  <= com_actual;
            end
          end else begin
            proto_err <= 1'b1;
          end
        end
        if (res_valid && res_ent.valid) begin
          tbl[res_rob_id].resolved  <= 1'b1;
          tbl[res_rob_id].mispred   <= res_mispred;
          tbl[res_rob_id].actual_pc <= res_actual;
        end
        // Allocation is written last so it overrides a same-tag commit or resolve.
        if (pred_valid && pred_is_br) begin
          tbl[pred_rob_id] <= '{valid:        1'b1,
                                resolved:     pred_is_jal,
                                mispred:      1'b0,
                                pred_next_pc: pred_next_pc,
                                fallthrough:  pred_fallthrough,
                                actual_pc:    pred_next_pc};
        end
      end
    end
  end

  assign flush_out       = flush_q & rdy_in;
  assign redirect_pc_out = redirect_q;
  assign branch_cnt_out  = branch_cnt;
  assign mispred_cnt_out = mispred_cnt;
  assign proto_err_out   = proto_err;

endmodule
